// File: rtl/adder_bist.sv
// adder_bist: clocked exhaustive self-test of a WIDTH-bit add/subtract unit.
// Sweeps every {m,a,b} vector, compares the adder's response to a golden sum, and reports the results.
module adder_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               m_o,
  input  logic [WIDTH-1:0]   s_i,
  input  logic               cout_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH+1:0] err_count,
  output logic [2*WIDTH:0]   first_fail
);
  localparam int IW = 2*WIDTH+1;
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] gold;
  logic mismatch, last, settled, accept;
  assign {m_o, a_o, b_o} = idx;
  // Subtract is a + ~b + 1 so cout reads as "no borrow".
  assign gold = {1'b0, a_o} + {1'b0, m_o ? ~b_o : b_o} + (WIDTH+1)'(m_o);
  assign mismatch = {cout_i, s_i} != gold;
  assign last = &idx;
  assign settled = cnt == CW'(SETTLE-1);
  assign accept = (state == IDLE || state == DONE) && start;
  assign busy = state == APPLY || state == CHECK;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = APPLY;
    else if (state == APPLY && settled) state_n = CHECK;
    else if (state == CHECK) state_n = last ? DONE : APPLY;
  end
  always_ff @(posedge clk)
    if (rst || accept) begin
      idx        <= '0;
      cnt        <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else if (state == APPLY) begin
      cnt <= settled ? '0 : cnt + 1'b1;
    end else if (state == CHECK) begin
      if (mismatch) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) first_fail <= idx;
      end
      if (!last) idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: drives two BIST instances (SETTLE=1 and SETTLE=3) against a behavioural adder with injectable faults.
module tb_adder_bist;
  logic clk = 0, rst = 1, start1 = 0, start3 = 0;
  int fault = 0;
  logic [3:0] a1, b1, s1, a3, b3, s3;
  logic m1, c1, busy1, done1, pass1, m3, c3, busy3, done3, pass3;
  logic [9:0] err1, err3;
  logic [8:0] ff1, ff3;
  int errors = 0, checks = 0;
  typedef struct { int err; int ff; bit pass; int cycles; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  adder_bist #(.WIDTH(4), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1), .m_o(m1),
    .s_i(s1), .cout_i(c1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1));
  adder_bist #(.WIDTH(4), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .start(start3), .a_o(a3), .b_o(b3), .m_o(m3),
    .s_i(s3), .cout_i(c3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .first_fail(ff3));

  // f=1: cout stuck at 0; f=2: s[0] inverted in subtract mode
  function automatic logic [4:0] add_model(logic [3:0] a, logic [3:0] b, logic m, int f);
    logic [4:0] r;
    r = m ? {1'b0, a} + {1'b0, ~b} + 5'd1 : {1'b0, a} + {1'b0, b};
    if (f == 1) r[4] = 1'b0;
    if (f == 2 && m) r[0] = ~r[0];
    return r;
  endfunction

  always_comb {c1, s1} = add_model(a1, b1, m1, fault);
  always_comb {c3, s3} = add_model(a3, b3, m3, fault);

  function automatic exp_t expect_for(int f, int settle);
    exp_t e;
    e.err = 0; e.ff = 0; e.cycles = 512 * (settle + 1);
    for (int i = 0; i < 512; i++) begin
      int m, a, b, sum;
      logic tc;
      logic [3:0] ts;
      m = i >> 8; a = (i >> 4) & 15; b = i & 15;
      if (m == 0) begin sum = a + b; ts = 4'(sum); tc = sum >= 16; end
      else begin ts = 4'(a - b); tc = a >= b; end
      if (add_model(4'(a), 4'(b), m[0], f) !== {tc, ts}) begin
        if (e.err == 0) e.ff = i;
        e.err++;
      end
    end
    e.pass = e.err == 0;
    return e;
  endfunction

  task automatic sweep(input int sel, input int f, input bit repulse);
    exp_t e;
    int cyc;
    logic d;
    fault = f;
    exp_q.push_back(expect_for(f, sel ? 3 : 1));
    @(negedge clk);
    if (sel) start3 = 1; else start1 = 1;
    @(posedge clk); #1;
    start1 = 0; start3 = 0;
    checks++;
    if ((sel ? {busy3, done3, a3, b3, m3, err3, ff3} : {busy1, done1, a1, b1, m1, err1, ff1}) !== {1'b1, 1'b0, 28'd0}) begin
      errors++; $display("FAIL start_state sel=%0d got busy=%b done=%b err=%0d", sel, sel ? busy3 : busy1, sel ? done3 : done1, sel ? err3 : err1);
    end
    cyc = 0; d = 0;
    while (!d && cyc < 6000) begin
      @(posedge clk); cyc++; #1;
      if (repulse) start1 = cyc == 99;
      d = sel ? done3 : done1;
    end
    start1 = 0;
    e = exp_q.pop_front();
    checks++;
    if (!d) begin errors++; $display("FAIL timeout sel=%0d waited %0d cycles", sel, cyc); end
    checks++;
    if (cyc != e.cycles) begin errors++; $display("FAIL cycles sel=%0d got %0d want %0d", sel, cyc, e.cycles); end
    checks++;
    if ((sel ? err3 : err1) !== 10'(e.err)) begin errors++; $display("FAIL err_count sel=%0d got %0d want %0d", sel, sel ? err3 : err1, e.err); end
    checks++;
    if ((sel ? ff3 : ff1) !== 9'(e.ff)) begin errors++; $display("FAIL first_fail sel=%0d got %0d want %0d", sel, sel ? ff3 : ff1, e.ff); end
    checks++;
    if ((sel ? pass3 : pass1) !== e.pass) begin errors++; $display("FAIL pass sel=%0d got %b want %b", sel, sel ? pass3 : pass1, e.pass); end
    checks++;
    if ((sel ? {busy3, a3, b3, m3} : {busy1, a1, b1, m1}) !== {1'b0, 9'h1ff}) begin
      errors++; $display("FAIL done_hold sel=%0d got busy=%b a=%0d b=%0d m=%b want 0/15/15/1", sel, sel ? busy3 : busy1, sel ? a3 : a1, sel ? b3 : b1, sel ? m3 : m1);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy1, done1, pass1, err1, ff1, a1, b1, m1, busy3, done3, pass3, err3, ff3, a3, b3, m3} !== 64'd0) begin
      errors++; $display("FAIL reset_outputs got busy=%b done=%b err=%0d a=%0d", busy1, done1, err1, a1);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_clean;       sweep(0, 0, 0); endtask
  task automatic test_cout_stuck;  sweep(0, 1, 0); endtask
  task automatic test_sub_s0_flip; sweep(0, 2, 0); endtask
  task automatic test_restart_ignored; sweep(0, 0, 1); endtask

  task automatic test_mid_reset;
    fault = 1;
    @(negedge clk); start1 = 1;
    @(posedge clk); #1; start1 = 0;
    repeat (299) @(posedge clk);
    #1;
    checks++;
    if (err1 === 10'd0 || busy1 !== 1'b1) begin errors++; $display("FAIL pre_reset got err=%0d busy=%b want err>0 busy=1", err1, busy1); end
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({busy1, done1, pass1, err1, ff1, a1, b1, m1} !== 32'd0) begin
      errors++; $display("FAIL mid_reset got busy=%b done=%b err=%0d ff=%0d a=%0d b=%0d m=%b want all 0", busy1, done1, err1, ff1, a1, b1, m1);
    end
    rst = 0;
    sweep(0, 0, 0);
  endtask

  task automatic test_back_to_back;
    sweep(1, 0, 0);
    sweep(1, 0, 0);
  endtask

  initial begin
    test_reset;
    test_clean;
    test_cout_stuck;
    test_sub_s0_flip;
    test_restart_ignored;
    test_mid_reset;
    test_back_to_back;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
